// File: rtl/spi_master_frame_ctrl.sv
// SPI master frame sequencer: drives cs/sclk for one framed transfer per start,
// with programmable cs setup, hold and inter-frame gap.
module spi_master_frame_ctrl #(
    parameter int FRAME_BITS      = 64,
    parameter int SCLK_HALFPERIOD = 1,
    parameter int CS_SETUP        = 1,
    parameter int CS_HOLD         = 1,
    parameter int MIN_GAP         = 2,
    parameter bit CPOL            = 1'b0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              cs,
    output logic                              sclk,
    output logic                              busy,
    output logic                              done,
    output logic                              overrun,
    output logic [$clog2(FRAME_BITS+1)-1:0]   bit_cnt
);

    localparam int BW    = $clog2(FRAME_BITS + 1);
    localparam int MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_B = (MIN_GAP > SCLK_HALFPERIOD) ? MIN_GAP : SCLK_HALFPERIOD;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_C + 1);

    localparam logic [CW-1:0] SETUP_LAST = CW'((CS_SETUP > 0) ? CS_SETUP - 1 : 0);
    localparam logic [CW-1:0] HOLD_LAST  = CW'((CS_HOLD > 0) ? CS_HOLD - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);
    localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALFPERIOD - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0] FULL       = BW'(FRAME_BITS);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hcnt;
    logic          pending;
    logic          shift_end;
    logic          fin;
    logic          gap_end;
    logic          go;

    // Last SHIFT cycle: the half-period that returns sclk to idle for the final bit
    assign shift_end = (state == SHIFT) && (sclk != CPOL) &&
                       (hcnt == HALF_LAST) && (bit_cnt == LAST_BIT);
    // Edge on which cs returns high
    assign fin       = ((state == HOLD) && (cnt == HOLD_LAST)) ||
                       ((CS_HOLD == 0) && shift_end);
    assign gap_end   = (state == GAP) && (cnt == GAP_LAST);
    assign go        = ((state == IDLE) || gap_end) && (start || pending);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cs      <= 1'b1;
            sclk    <= CPOL;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            pending <= 1'b0;
            bit_cnt <= '0;
            cnt     <= '0;
            hcnt    <= '0;
        end else begin
            done <= fin;
            if (go) begin
                cs      <= 1'b0;
                busy    <= 1'b1;
                sclk    <= CPOL;
                bit_cnt <= '0;
                overrun <= 1'b0;
                pending <= 1'b0;
                cnt     <= '0;
                hcnt    <= '0;
                state   <= (CS_SETUP > 0) ? SETUP : SHIFT;
            end else begin
                unique case (state)
                    IDLE: begin
                        busy <= 1'b0;
                    end
                    SETUP: begin
                        if (start) overrun <= 1'b1;
                        if (cnt == SETUP_LAST) begin
                            state <= SHIFT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (start) begin
                            if (fin) pending <= 1'b1;
                            else     overrun <= 1'b1;
                        end
                        if (hcnt == HALF_LAST) begin
                            hcnt <= '0;
                            sclk <= ~sclk;
                            if (sclk != CPOL && bit_cnt != FULL)
                                bit_cnt <= bit_cnt + 1'b1;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                        if (shift_end) begin
                            cnt <= '0;
                            if (CS_HOLD > 0) begin
                                state <= HOLD;
                            end else begin
                                cs <= 1'b1;
                                if (MIN_GAP > 0) begin
                                    state <= GAP;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        if (start) begin
                            if (fin) pending <= 1'b1;
                            else     overrun <= 1'b1;
                        end
                        if (fin) begin
                            cs  <= 1'b1;
                            cnt <= '0;
                            if (MIN_GAP > 0) begin
                                state <= GAP;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (start) begin
                            if (pending) overrun <= 1'b1;
                            else         pending <= 1'b1;
                        end
                        if (gap_end) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_master_frame_ctrl.sv
// Bench for spi_master_frame_ctrl: three parameterisations checked cycle by
// cycle against a frame-offset reference model plus directed frame measurements.
module tb_spi_master_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] st  = 3'b000;

    always #5 clk = ~clk;

    logic cs_a, sclk_a, bz_a, dn_a, ov_a;
    logic [6:0] bc_a;
    logic cs_b, sclk_b, bz_b, dn_b, ov_b;
    logic [2:0] bc_b;
    logic cs_c, sclk_c, bz_c, dn_c, ov_c;
    logic [3:0] bc_c;

    spi_master_frame_ctrl u_a (
        .clk(clk), .rst(rst), .start(st[0]), .cs(cs_a), .sclk(sclk_a),
        .busy(bz_a), .done(dn_a), .overrun(ov_a), .bit_cnt(bc_a)
    );

    spi_master_frame_ctrl #(
        .FRAME_BITS(4), .SCLK_HALFPERIOD(3), .CPOL(1'b1)
    ) u_b (
        .clk(clk), .rst(rst), .start(st[1]), .cs(cs_b), .sclk(sclk_b),
        .busy(bz_b), .done(dn_b), .overrun(ov_b), .bit_cnt(bc_b)
    );

    spi_master_frame_ctrl #(
        .FRAME_BITS(8), .CS_SETUP(0), .CS_HOLD(0), .MIN_GAP(0)
    ) u_c (
        .clk(clk), .rst(rst), .start(st[2]), .cs(cs_c), .sclk(sclk_c),
        .busy(bz_c), .done(dn_c), .overrun(ov_c), .bit_cnt(bc_c)
    );

    int FB_[3] = '{64, 4, 8};
    int HP_[3] = '{1, 3, 1};
    int SU_[3] = '{1, 1, 0};
    int HO_[3] = '{1, 1, 0};
    int GP_[3] = '{2, 2, 0};
    bit CP_[3] = '{1'b0, 1'b1, 1'b0};

    typedef struct {
        bit v;
        int L;
        bit pend;
        bit ovr;
    } mst_t;

    mst_t ms[3];
    int   cyc   = 0;
    int   nchk  = 0;
    int   npass = 0;

    function automatic int tlen(int i);
        return SU_[i] + 2 * FB_[i] * HP_[i] + HO_[i];
    endfunction

    // Reference: a frame launched on edge L owns cs-low cycles L+1..L+T
    function automatic void model_edge(int i, bit s, bit r, int e);
        int  t, g, p;
        bit  launch;
        t = tlen(i);
        g = GP_[i];
        launch = 1'b0;
        if (r) begin
            ms[i].v = 1'b0; ms[i].pend = 1'b0; ms[i].ovr = 1'b0;
            return;
        end
        if (!ms[i].v) begin
            launch = s || ms[i].pend;
        end else begin
            p = e - ms[i].L;
            if (p < t) begin
                if (s) ms[i].ovr = 1'b1;
            end else if (p == t) begin
                if (s) ms[i].pend = 1'b1;
            end else if (g > 0 && p < t + g) begin
                if (s && ms[i].pend) ms[i].ovr = 1'b1;
                else if (s) ms[i].pend = 1'b1;
            end else begin
                launch = s || ms[i].pend;
            end
        end
        if (launch) begin
            ms[i].v = 1'b1; ms[i].L = e; ms[i].pend = 1'b0; ms[i].ovr = 1'b0;
        end
    endfunction

    function automatic logic [11:0] exp_vec(int i);
        int   t, j, m, bc;
        logic c, s, b, d;
        t = tlen(i);
        c = 1'b1; s = CP_[i]; b = 1'b0; d = 1'b0; bc = 0;
        if (ms[i].v) begin
            j = cyc - ms[i].L;
            m = j - SU_[i];
            c = (j >= t);
            d = (j == t);
            b = (j < t + GP_[i]);
            if (m >= 0 && m < 2 * FB_[i] * HP_[i]) begin
                s  = CP_[i] ^ (((m / HP_[i]) % 2) == 1);
                bc = m / (2 * HP_[i]);
            end else if (m >= 0) begin
                bc = FB_[i];
            end
        end
        return {c, s, b, d, ms[i].ovr, 7'(bc)};
    endfunction

    function automatic logic [11:0] act_vec(int i);
        if (i == 0) return {cs_a, sclk_a, bz_a, dn_a, ov_a, bc_a};
        if (i == 1) return {cs_b, sclk_b, bz_b, dn_b, ov_b, 4'b0, bc_b};
        return {cs_c, sclk_c, bz_c, dn_c, ov_c, 3'b0, bc_c};
    endfunction

    task automatic step(input logic [2:0] s, input logic r);
        st  = s;
        rst = r;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 3; i++) model_edge(i, s[i], r, cyc);
        #1;
    endtask

    task automatic test_reset();
        step(3'b000, 1'b1);
        step(3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            nchk++;
            if (act_vec(i) !== exp_vec(i))
                $display("FAIL reset inst%0d got %h exp %h", i, act_vec(i), exp_vec(i));
            else npass++;
        end
        nchk++;
        if ({cs_b, sclk_b, bz_b, dn_b, ov_b, bc_b} !== 8'b1100_0000)
            $display("FAIL reset_cpol1 got %b exp 11000000",
                     {cs_b, sclk_b, bz_b, dn_b, ov_b, bc_b});
        else npass++;
        step(3'b000, 1'b0);
    endtask

    task automatic test_single_frame();
        int   se, low, rises, busyc, donec, donepos;
        logic prev;
        low = 0; rises = 0; busyc = 0; donec = 0; donepos = -1;
        prev = sclk_a;
        step(3'b001, 1'b0);
        se = cyc;
        for (int n = 0; n < 145; n++) begin
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL frame inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
            if (!cs_a) low++;
            if (bz_a) busyc++;
            if (!prev && sclk_a) rises++;
            prev = sclk_a;
            if (dn_a) begin donec++; donepos = cyc + 1 - se; end
            step(3'b000, 1'b0);
        end
        nchk++;
        if (low !== 130) $display("FAIL cs_low_len got %0d exp 130", low);
        else npass++;
        nchk++;
        if (rises !== 64) $display("FAIL sclk_rises got %0d exp 64", rises);
        else npass++;
        nchk++;
        if (donec !== 1 || donepos !== 131)
            $display("FAIL done_pos got %0d/%0d exp 1/131", donec, donepos);
        else npass++;
        nchk++;
        if (busyc !== 132) $display("FAIL busy_len got %0d exp 132", busyc);
        else npass++;
        nchk++;
        if (bc_a !== 7'd64) $display("FAIL bit_cnt_end got %0d exp 64", bc_a);
        else npass++;
    endtask

    task automatic test_slow_clk();
        int   low, zeros, rises;
        logic prev;
        low = 0; zeros = 0; rises = 0;
        prev = sclk_b;
        step(3'b010, 1'b0);
        for (int n = 0; n < 35; n++) begin
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL slow inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
            if (!cs_b) low++;
            if (!sclk_b) zeros++;
            if (!prev && sclk_b) rises++;
            prev = sclk_b;
            step(3'b000, 1'b0);
        end
        nchk++;
        if (low !== 26) $display("FAIL slow_cs_low got %0d exp 26", low);
        else npass++;
        nchk++;
        if (zeros !== 12 || rises !== 4)
            $display("FAIL slow_sclk got %0d/%0d exp 12/4", zeros, rises);
        else npass++;
    endtask

    task automatic test_overrun();
        int k, low;
        k = $urandom_range(3, 120);
        low = 0;
        step(3'b001, 1'b0);
        for (int n = 1; n <= 145; n++) begin
            if (!cs_a) low++;
            step({2'b00, n == k}, 1'b0);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL overrun inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
        end
        nchk++;
        if (ov_a !== 1'b1 || low !== 130)
            $display("FAIL overrun_set got %b/%0d exp 1/130", ov_a, low);
        else npass++;
        step(3'b001, 1'b0);
        nchk++;
        if (ov_a !== 1'b0) $display("FAIL overrun_clear got %b exp 0", ov_a);
        else npass++;
        for (int n = 0; n < 140; n++) step(3'b000, 1'b0);
    endtask

    task automatic test_gap_start();
        int   k, rise, fall, blow;
        logic prev;
        k = $urandom_range(0, 2);
        rise = -1; fall = -1; blow = 0;
        step(3'b001, 1'b0);
        prev = cs_a;
        for (int n = 1; n <= 280; n++) begin
            step({2'b00, n == 130 + k}, 1'b0);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL gap inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
            if (!prev && cs_a && rise < 0) rise = cyc + 1;
            if (rise >= 0 && prev && !cs_a && fall < 0) fall = cyc + 1;
            if (rise >= 0 && fall < 0 && !bz_a) blow++;
            prev = cs_a;
        end
        nchk++;
        if (fall - rise !== 2 || blow !== 0)
            $display("FAIL gap_relaunch got %0d/%0d exp 2/0", fall - rise, blow);
        else npass++;
        nchk++;
        if (ov_a !== 1'b0) $display("FAIL gap_overrun got %b exp 0", ov_a);
        else npass++;
    endtask

    task automatic test_back_to_back();
        int   se, hi, dc, ovs;
        hi = 0; dc = 0; ovs = 0;
        step(3'b100, 1'b0);
        se = cyc;
        for (int n = 1; n <= 60; n++) begin
            step({n == 16 || n == 33, 2'b00}, 1'b0);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL b2b inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
            if (cs_c && cyc + 1 < se + 51) hi++;
            if (dn_c) dc++;
            if (ov_c) ovs++;
        end
        nchk++;
        if (hi !== 2 || dc !== 3 || ovs !== 0)
            $display("FAIL b2b_frames got %0d/%0d/%0d exp 2/3/0", hi, dc, ovs);
        else npass++;
    endtask

    task automatic test_reset_mid();
        int n, low, dc;
        low = 0; dc = 0;
        step(3'b001, 1'b0);
        n = 0;
        while (bc_a !== 7'd20 && n < 200) begin
            step(3'b000, 1'b0);
            n++;
        end
        nchk++;
        if (bc_a !== 7'd20) $display("FAIL reach_bit20 got %0d exp 20", bc_a);
        else npass++;
        step(3'b000, 1'b1);
        nchk++;
        if ({cs_a, sclk_a, bz_a, dn_a, bc_a} !== 11'b100_0000_0000)
            $display("FAIL rst_mid got %b exp 10000000000",
                     {cs_a, sclk_a, bz_a, dn_a, bc_a});
        else npass++;
        for (int m = 0; m < 5; m++) begin
            step(3'b000, 1'b0);
            nchk++;
            if (act_vec(0) !== exp_vec(0) || dn_a !== 1'b0)
                $display("FAIL rst_quiet cyc%0d got %h exp %h", cyc, act_vec(0), exp_vec(0));
            else npass++;
        end
        step(3'b001, 1'b0);
        for (int m = 0; m < 140; m++) begin
            if (!cs_a) low++;
            if (dn_a) dc++;
            step(3'b000, 1'b0);
        end
        nchk++;
        if (low !== 130 || dc !== 1)
            $display("FAIL rst_refrain got %0d/%0d exp 130/1", low, dc);
        else npass++;
    endtask

    task automatic test_random();
        logic [2:0] s;
        logic       r;
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < 3; i++) s[i] = ($urandom_range(0, 39) == 0);
            r = ($urandom_range(0, 599) == 0);
            step(s, r);
            for (int i = 0; i < 3; i++) begin
                nchk++;
                if (act_vec(i) !== exp_vec(i))
                    $display("FAIL random inst%0d cyc%0d got %h exp %h",
                             i, cyc, act_vec(i), exp_vec(i));
                else npass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_slow_clk();
        test_overrun();
        test_gap_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
